mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the instruction fetch path (IF, read-only) and the data path (MEM stage, lw/sw).
- Sits between the core's fetch and MEM-stage logic and the memory.
- Holds one transaction in flight at a time, using a 3-state FSM.
- Data port has priority because it is the older instruction. A streak counter stops the fetch port from starving.

---
 rtl/mem_port_arbiter_pkg.sv | 6 +
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} arb_state_t;
  typedef enum logic {IF, DATA} arb_owner_t;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a fetch anti-starvation streak counter
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic if_win,
  output logic d_win
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SAT = SW'(STARVE_LIMIT);
  logic [SW-1:0] streak;
  // fetch wins when alone or once data has won SAT times in a row over it
  always_comb begin
    if_win = if_req && (!d_req || (STARVE_LIMIT > 0 && streak == SAT));
    d_win = d_req && !if_win;
  end
  // streak counts data grants taken while fetch waits, saturating
  always_ff @(posedge clk) begin
    if (rst || !if_req || if_gnt) streak <= '0;
    else if (d_gnt && streak != SAT) streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports (stats counters under MEM_ARB_STATS_EN)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_wait,
  output logic [31:0]       stat_d_wait
`endif
);
  arb_state_t state, state_d;
  arb_owner_t owner, owner_d;
  logic req_d, we_d, if_win, d_win, acc, rsp;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk(clk), .rst(rst), .if_req(if_req), .d_req(d_req),
    .if_gnt(if_gnt), .d_gnt(d_gnt), .if_win(if_win), .d_win(d_win)
  );

  // handshakes are suppressed during reset so nothing leaks from an aborted transaction
  always_comb begin
    acc = !rst && state == ISSUE && mem_ready;
    rsp = !rst && state == WAIT_RD && mem_rvalid;
    if_gnt = acc && owner == IF;
    d_gnt = acc && owner == DATA;
    if_rvalid = rsp && owner == IF;
    d_rvalid = rsp && owner == DATA;
    if_rdata = if_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? mem_rdata : '0;
  end

  // next-state: latch winner in IDLE, hold until ready, then wait for read data
  always_comb begin
    state_d = state;
    owner_d = owner;
    req_d = mem_req;
    we_d = mem_we;
    addr_d = mem_addr;
    wdata_d = mem_wdata;
    if (state == IDLE && (if_win || d_win)) begin
      state_d = ISSUE;
      owner_d = if_win ? IF : DATA;
      req_d = 1'b1;
      we_d = if_win ? 1'b0 : d_we;
      addr_d = if_win ? if_addr : d_addr;
      wdata_d = if_win ? '0 : d_wdata;
    end else if (state == ISSUE && mem_ready) begin
      req_d = 1'b0;
      state_d = (owner == DATA && mem_we) ? IDLE : WAIT_RD;
    end else if (state == WAIT_RD && mem_rvalid) begin
      state_d = IDLE;
    end
  end

  // FSM and registered memory request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= DATA;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      mem_req <= req_d;
      mem_we <= we_d;
      mem_addr <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // wrapping counts of cycles each port spends requesting without a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_wait <= '0;
      stat_d_wait <= '0;
    end else begin
      stat_if_wait <= stat_if_wait + {31'b0, if_req && !if_gnt};
      stat_d_wait <= stat_d_wait + {31'b0, d_req && !d_gnt};
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, starvation sequence and random run against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_wait, stat_d_wait;
`endif
  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_wait(stat_if_wait), .stat_d_wait(stat_d_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, ifr, dr, dwe, rdy, rv, cf;
    logic [31:0] ifa, da, dwd, rd;
    logic [68:0] eo;
    logic [64:0] ef;
  } vec_t;

  function automatic vec_t v(logic r, logic ifr, logic [31:0] ifa, logic dr, logic dwe, logic [31:0] da,
                             logic [31:0] dwd, logic rdy, logic rv, logic [31:0] rd,
                             logic ig, logic iv, logic [31:0] ird, logic dg, logic dv, logic [31:0] drd,
                             logic mr, logic cf, logic mwe, logic [31:0] ma, logic [31:0] mwd);
    vec_t x;
    x.r = r; x.ifr = ifr; x.ifa = ifa; x.dr = dr; x.dwe = dwe; x.da = da; x.dwd = dwd;
    x.rdy = rdy; x.rv = rv; x.rd = rd; x.cf = cf;
    x.eo = {ig, iv, ird, dg, dv, drd, mr};
    x.ef = {mwe, ma, mwd};
    return x;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic row(vec_t x, string nm);
    @(negedge clk);
    rst = x.r; if_req = x.ifr; if_addr = x.ifa; d_req = x.dr; d_we = x.dwe; d_addr = x.da;
    d_wdata = x.dwd; mem_ready = x.rdy; mem_rvalid = x.rv; mem_rdata = x.rd;
    #1;
    chk({nm, "_out"}, {59'b0, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req}, {59'b0, x.eo});
    if (x.cf) chk({nm, "_mem"}, {63'b0, mem_we, mem_addr, mem_wdata}, {63'b0, x.ef});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  vec_t tbl[$];
  vec_t st[$];
  int gq[$];
  bit busy, issued, waiting, t_if, t_we, ih, dh;
  logic [31:0] t_addr, t_wdata;
  logic e_ig, e_iv, e_dg, e_dv;
  int rd_wait, streak;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,1,'h100,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,1,'h100,0,0,0,0,1,0,0, 1,0,0,0,0,0, 1,1,0,'h100,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'hDEADBEEF, 0,1,'hDEADBEEF,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h104,1,0,'h200,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h104,1,0,'h200,0,1,0,0, 0,0,0,1,0,0, 1,1,0,'h200,0));
    tbl.push_back(v(0,1,'h104,0,0,0,0,0,1,'h12345678, 0,0,0,0,1,'h12345678, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h104,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h104,0,0,0,0,1,0,0, 1,0,0,0,0,0, 1,1,0,'h104,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'hCAFEF00D, 0,1,'hCAFEF00D,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,1,'h40,'h55,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,0,0,1,1,'h40,'h55,0,0,0, 0,0,0,0,0,0, 1,1,1,'h40,'h55));
    tbl.push_back(v(0,0,0,1,1,'h40,'h55,1,0,0, 0,0,0,1,0,0, 1,1,1,'h40,'h55));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h77, 0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h300,0,0,0,0,0,1,'h99, 0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,'h300,0,0,0,0,0,1,'h99, 0,0,0,0,0,0, 1,1,0,'h300,0));
    tbl.push_back(v(0,1,'h300,0,0,0,0,1,0,0, 1,0,0,0,0,0, 1,1,0,'h300,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,1,'hAA, 0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'hAA, 0,0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0));
    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) row(tbl[i], $sformatf("vec%0d", i));

    st.push_back(v(0,1,'h104,1,0,'h200,0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    st.push_back(v(0,1,'h104,1,0,'h200,0,1,0,0, 0,0,0,1,0,0, 1,1,0,'h200,0));
    st.push_back(v(0,1,'h104,0,0,0,0,1,1,'h11, 0,0,0,0,1,'h11, 0,0,0,0,0));
    st.push_back(v(0,1,'h104,0,0,0,0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    st.push_back(v(0,1,'h104,0,0,0,0,1,0,0, 1,0,0,0,0,0, 1,1,0,'h104,0));
    st.push_back(v(0,0,0,0,0,0,0,0,1,'h22, 0,1,'h22,0,0,0, 0,0,0,0,0));
    do_reset();
    for (int i = 0; i < st.size(); i++) row(st[i], $sformatf("sim%0d", i));
`ifdef MEM_ARB_STATS_EN
    chk("stat_if_wait", {96'b0, stat_if_wait}, 128'd4);
    chk("stat_d_wait", {96'b0, stat_d_wait}, 128'd1);
`endif

    do_reset();
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      rst = 1'b0; if_req = 1'b1; if_addr = 'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 'h600;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 'h33;
      #1;
      if (if_gnt) gq.push_back(1);
      if (d_gnt) gq.push_back(0);
    end
    chk("starve_count", {96'b0, 32'(gq.size() >= 10)}, 128'd1);
    for (int k = 0; k < 10 && k < gq.size(); k++)
      chk($sformatf("starve_gnt%0d", k), {96'b0, 32'(gq[k])}, {96'b0, 32'(k % 5 == 4)});

    do_reset();
    busy = 0; issued = 0; waiting = 0; t_if = 0; t_we = 0; ih = 0; dh = 0;
    t_addr = '0; t_wdata = '0; rd_wait = 0; streak = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (!ih) begin
        if_req = 1'($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'h0000_0FFC;
      end
      if (!dh) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'h0000_0FFC;
        d_wdata = $urandom;
      end
      mem_ready = 1'($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      mem_rvalid = waiting ? (rd_wait == 0) : 1'($urandom_range(0, 7) == 0);
      #1;
      e_ig = issued && mem_ready && t_if;
      e_dg = issued && mem_ready && !t_if;
      e_iv = waiting && mem_rvalid && t_if;
      e_dv = waiting && mem_rvalid && !t_if;
      chk($sformatf("rand%0d_out", c), {59'b0, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req},
          {59'b0, e_ig, e_iv, e_iv ? mem_rdata : 32'h0, e_dg, e_dv, e_dv ? mem_rdata : 32'h0, issued});
      if (issued) chk($sformatf("rand%0d_mem", c), {95'b0, mem_we, mem_addr}, {95'b0, t_we, t_addr});
      if (issued && t_we) chk($sformatf("rand%0d_wdata", c), {96'b0, mem_wdata}, {96'b0, t_wdata});
      if (!busy) begin
        if (if_req || d_req) begin
          t_if = if_req && (!d_req || streak == LIM);
          t_we = !t_if && d_we;
          t_addr = t_if ? if_addr : d_addr;
          t_wdata = d_wdata;
          busy = 1; issued = 1;
        end
      end else if (issued) begin
        if (mem_ready) begin
          issued = 0;
          if (t_we) busy = 0;
          else begin
            waiting = 1;
            rd_wait = $urandom_range(0, 3);
          end
        end
      end else if (mem_rvalid) begin
        waiting = 0; busy = 0;
      end else rd_wait--;
      streak = (!if_req || e_ig) ? 0 : (e_dg && streak < LIM) ? streak + 1 : streak;
      ih = if_req && !e_ig;
      dh = d_req && !e_dg;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
